// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall controller for an N-stage in-order pipeline.
// Drives PC and per-latch enable/flush controls and keeps saturating performance counters.
module pipe_hazard_ctrl #(
   parameter int NSTAGES  = 5,
   parameter int BR_STAGE = 2,
   parameter int LOAD_LAT = 1,
   parameter int REGW     = 5,
   parameter int CNTW     = 16
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                ihit,
   input  logic                dhit,
   input  logic                mem_dren,
   input  logic                mem_dwen,
   input  logic                ex_dren,
   input  logic [REGW-1:0]     ex_wsel,
   input  logic [REGW-1:0]     id_rs,
   input  logic [REGW-1:0]     id_rt,
   input  logic                id_uses_rt,
   input  logic                redirect,
   input  logic                wb_halt,
   output logic                pc_en,
   output logic [NSTAGES-2:0]  latch_en,
   output logic [NSTAGES-2:0]  latch_flush,
   output logic                halted,
   output logic [CNTW-1:0]     stall_cnt,
   output logic [CNTW-1:0]     flush_cnt
);
   localparam int NL = NSTAGES - 1;
   localparam logic [NL-1:0] ALL      = '1;
   localparam logic [NL-1:0] BR_MASK  = ALL >> (NL - BR_STAGE);
   localparam logic [NL-1:0] LU_EN    = ALL ^ NL'(1);
   localparam logic [NL-1:0] LU_FLUSH = NL'(2);
   localparam logic [NL-1:0] IF_FLUSH = NL'(1);

   typedef enum logic [1:0] {RUN, LDUSE, HALT} state_t;

   state_t     state;
   logic [3:0] rem;
   logic       dfreeze;
   logic       lu_hit;
   logic       lu_act;
   logic       blocked;

   // load-use bubbles stay in force while LDUSE, independent of the current EX/ID pair
   always_comb begin
      dfreeze     = (mem_dren | mem_dwen) & ~dhit;
      lu_hit      = ex_dren && ex_wsel != '0 &&
                    (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
      lu_act      = state == LDUSE || lu_hit;
      blocked     = !nRST || state == HALT || dfreeze;
      pc_en       = blocked ? 1'b0 : redirect ? 1'b1 : lu_act ? 1'b0 : ihit;
      latch_en    = blocked ? '0 : (lu_act && !redirect) ? LU_EN : ALL;
      latch_flush = blocked ? '0 : redirect ? BR_MASK : lu_act ? LU_FLUSH :
                    !ihit ? IF_FLUSH : '0;
      halted      = nRST && state == HALT;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         rem       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state != HALT) begin
         if (!pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNTW'(1);
         if (!dfreeze) begin
            if (redirect && flush_cnt != '1)
               flush_cnt <= flush_cnt + CNTW'(1);
            if (wb_halt) begin
               state <= HALT;
               rem   <= '0;
            end else if (redirect) begin
               state <= RUN;
               rem   <= '0;
            end else if (state == LDUSE) begin
               rem <= rem - 4'd1;
               if (rem == 4'd1)
                  state <= RUN;
            end else if (lu_hit && LOAD_LAT > 1) begin
               state <= LDUSE;
               rem   <= 4'(LOAD_LAT - 1);
            end
         end
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: random and directed checks of three configurations of pipe_hazard_ctrl
// against a bubble-count reference model.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic ihit, dhit, mem_dren, mem_dwen, ex_dren, id_uses_rt, redirect, wb_halt;
   logic [4:0] ex_wsel, id_rs, id_rt;

   logic       pc [3];
   logic [3:0] le [3];
   logic [3:0] lf [3];
   logic       hl [3];
   logic [15:0] sc0, fc0, sc1, fc1;
   logic [3:0]  sc2, fc2;

   int checks = 0;
   int failures = 0;

   bit m_halt [3];
   int m_bub [3];
   int m_stall [3];
   int m_flush [3];
   int lat [3] = '{1, 3, 1};
   int cmax [3] = '{65535, 65535, 15};

   always #5 clk = ~clk;

   pipe_hazard_ctrl u0 (
      .CLK(clk), .nRST(rst_n), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .ex_dren(ex_dren), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .redirect(redirect), .wb_halt(wb_halt), .pc_en(pc[0]), .latch_en(le[0]), .latch_flush(lf[0]),
      .halted(hl[0]), .stall_cnt(sc0), .flush_cnt(fc0));

   pipe_hazard_ctrl #(.LOAD_LAT(3)) u1 (
      .CLK(clk), .nRST(rst_n), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .ex_dren(ex_dren), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .redirect(redirect), .wb_halt(wb_halt), .pc_en(pc[1]), .latch_en(le[1]), .latch_flush(lf[1]),
      .halted(hl[1]), .stall_cnt(sc1), .flush_cnt(fc1));

   pipe_hazard_ctrl #(.CNTW(4)) u2 (
      .CLK(clk), .nRST(rst_n), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .ex_dren(ex_dren), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .redirect(redirect), .wb_halt(wb_halt), .pc_en(pc[2]), .latch_en(le[2]), .latch_flush(lf[2]),
      .halted(hl[2]), .stall_cnt(sc2), .flush_cnt(fc2));

   function automatic bit hazard();
      return ex_dren && ex_wsel != 0 && (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
   endfunction

   function automatic bit freeze();
      return (mem_dren || mem_dwen) && !dhit;
   endfunction

   // {pc_en, latch_en, latch_flush, halted, stall_cnt, flush_cnt} the spec's priority list predicts
   function automatic logic [41:0] exp_vec(int i);
      logic [9:0] o;
      if (!rst_n) o = 10'b0_0000_0000_0;
      else if (m_halt[i]) o = 10'b0_0000_0000_1;
      else if (freeze()) o = 10'b0_0000_0000_0;
      else if (redirect) o = 10'b1_1111_0011_0;
      else if (m_bub[i] > 0 || hazard()) o = 10'b0_1110_0010_0;
      else if (!ihit) o = 10'b0_1111_0001_0;
      else o = 10'b1_1111_0000_0;
      return {o, 16'(m_stall[i]), 16'(m_flush[i])};
   endfunction

   function automatic logic [41:0] obs(int i);
      logic [15:0] s, f;
      s = i == 0 ? sc0 : i == 1 ? sc1 : {12'b0, sc2};
      f = i == 0 ? fc0 : i == 1 ? fc1 : {12'b0, fc2};
      return {pc[i], le[i], lf[i], hl[i], s, f};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_halt[i] = 0; m_bub[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end
   endtask

   task automatic model_update();
      logic [41:0] v;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n || m_halt[i]) continue;
         v = exp_vec(i);
         if (!v[41]) m_stall[i] = m_stall[i] < cmax[i] ? m_stall[i] + 1 : cmax[i];
         if (freeze()) continue;
         if (redirect) begin
            m_flush[i] = m_flush[i] < cmax[i] ? m_flush[i] + 1 : cmax[i];
            m_bub[i] = 0;
         end else if (m_bub[i] > 0) m_bub[i]--;
         else if (hazard()) m_bub[i] = lat[i] - 1;
         if (wb_halt) m_halt[i] = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      ihit = 1; dhit = 1; mem_dren = 0; mem_dwen = 0; ex_dren = 0; id_uses_rt = 0;
      redirect = 0; wb_halt = 0; ex_wsel = 0; id_rs = 0; id_rt = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      logic [41:0] o, e;
      idle_inputs();
      rst_n = 0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         o = obs(i); checks++;
         if (o !== 42'd0) begin failures++; $display("FAIL reset_state dut%0d got=%h exp=0", i, o); end
      end
      tick();
      rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         o = obs(i); e = exp_vec(i); checks++;
         if (o !== e) begin failures++; $display("FAIL reset_release dut%0d got=%h exp=%h", i, o, e); end
      end
      tick();
   endtask

   task automatic test_load_use();
      logic [41:0] o, e;
      int b0 = 0, b1 = 0;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         if (c == 0) begin ex_dren = 1; ex_wsel = 8; id_rs = 8; end
         @(negedge clk);
         b0 += !pc[0]; b1 += !pc[1];
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL load_use c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         tick();
      end
      checks++;
      if (b0 !== 1 || b1 !== 3) begin
         failures++; $display("FAIL bubble_count got=%0d/%0d exp=1/3", b0, b1);
      end
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         ex_dren = 1; ex_wsel = 8;
         if (c == 0) begin ex_wsel = 0; id_rs = 0; end
         if (c == 1) begin id_rs = 3; id_rt = 8; id_uses_rt = 0; end
         if (c == 2) begin id_rs = 3; id_rt = 8; id_uses_rt = 1; end
         @(negedge clk);
         checks++;
         if (pc[0] !== (c != 2)) begin
            failures++; $display("FAIL lu_qualify c%0d got=%b exp=%b", c, pc[0], c != 2);
         end
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL lu_qualify c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         tick();
      end
      idle_inputs();
      repeat (3) tick();
   endtask

   task automatic test_reset_lduse();
      logic [41:0] o, e;
      idle_inputs();
      ex_dren = 1; ex_wsel = 8; id_rs = 8;
      tick();
      idle_inputs();
      #1;
      rst_n = 0;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         o = obs(i); checks++;
         if (o !== 42'd0) begin failures++; $display("FAIL async_reset dut%0d got=%h exp=0", i, o); end
      end
      rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         o = obs(i); e = exp_vec(i); checks++;
         if (o !== e || o[41:32] !== 10'b1_1111_0000_0) begin
            failures++; $display("FAIL async_reset_resume dut%0d got=%h exp=%h", i, o, e);
         end
      end
      tick();
   endtask

   task automatic test_data_wait();
      logic [41:0] o, e;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         if (c < 4) begin mem_dren = 1; redirect = 1; dhit = c == 3; end
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL data_wait c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         if (c == 3) begin
            checks++;
            if (sc0 !== 16'd3 || lf[0] !== 4'b0011) begin
               failures++; $display("FAIL data_wait_release stall=%0d flush=%b exp=3/0011", sc0, lf[0]);
            end
         end
         tick();
      end
      checks++;
      if (fc0 !== 16'd1) begin failures++; $display("FAIL data_wait_flush_cnt got=%0d exp=1", fc0); end
   endtask

   task automatic test_redirect_lduse();
      logic [41:0] o, e;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         if (c == 0) begin ex_dren = 1; ex_wsel = 9; id_rs = 9; end
         if (c == 1) begin redirect = 1; ihit = 0; end
         @(negedge clk);
         if (c >= 1) begin
            checks++;
            if (pc[1] !== 1'b1 || (c == 1 && lf[1] !== 4'b0011)) begin
               failures++; $display("FAIL redirect_lduse c%0d pc=%b flush=%b exp pc=1", c, pc[1], lf[1]);
            end
         end
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL redirect_lduse c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         tick();
      end
   endtask

   task automatic test_fetch_miss();
      logic [41:0] o, e;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         ihit = c == 2;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL fetch_miss c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         tick();
      end
      checks++;
      if (sc0 !== 16'd2) begin failures++; $display("FAIL fetch_miss_stall_cnt got=%0d exp=2", sc0); end
   endtask

   task automatic test_halt_sat();
      logic [41:0] o, e;
      do_reset();
      for (int c = 0; c < 27; c++) begin
         idle_inputs();
         ihit = c >= 20;
         wb_halt = c == 20;
         if (c > 21) begin
            ihit = 1'($urandom); redirect = 1'($urandom); ex_dren = 1'($urandom); ex_wsel = 5'($urandom);
            id_rs = ex_wsel;
         end
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL halt_sat c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         tick();
      end
      checks++;
      if (sc2 !== 4'hF || hl[2] !== 1'b1 || pc[2] !== 1'b0 || le[2] !== 4'b0000) begin
         failures++; $display("FAIL halt_saturate stall=%h halted=%b en=%b exp F/1/0000", sc2, hl[2], le[2]);
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [41:0] o, e;
      for (int c = 0; c < 600; c++) begin
         ihit = $urandom_range(0, 3) != 0;
         dhit = $urandom_range(0, 2) != 0;
         mem_dren = $urandom_range(0, 3) == 0;
         mem_dwen = $urandom_range(0, 5) == 0;
         ex_dren = $urandom_range(0, 1) == 0;
         ex_wsel = 5'($urandom_range(0, 3));
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         id_uses_rt = 1'($urandom);
         redirect = $urandom_range(0, 5) == 0;
         wb_halt = $urandom_range(0, 80) == 0;
         if ($urandom_range(0, 40) == 0) begin
            rst_n = 0;
            model_reset();
         end
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            o = obs(i); e = exp_vec(i); checks++;
            if (o !== e) begin failures++; $display("FAIL random c%0d dut%0d got=%h exp=%h", c, i, o, e); end
         end
         tick();
         rst_n = 1;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_reset_lduse();
      test_data_wait();
      test_redirect_lduse();
      test_fetch_miss();
      test_halt_sat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard/stall controller for an N-stage in-order MIPS pipeline. Next generation of the fixed 5-stage hazard unit.
- Drives the PC enable and per-latch enable/flush controls.
- Handles memory-wait freezes, multi-cycle load-use bubbles (FSM plus counter), branch/jump redirects and halt.
- Keeps saturating stall and flush counters for performance monitoring.
- Stage 0 = IF, stage 1 = ID, stage 2 = EX. Latch k sits between stage k and stage k+1.

Parameters:
- NSTAGES, 5, pipeline stage count (>=4); there are NSTAGES-1 latches.
- BR_STAGE, 2, stage resolving branches/jumps/JR (1..NSTAGES-2); latches 0..BR_STAGE-1 are flushed on redirect.
- LOAD_LAT, 1, load-use bubbles inserted per hazard (1..15).
- REGW, 5, register address width.
- CNTW, 16, performance counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dren  in  1  load in memory stage.
- mem_dwen  in  1  store in memory stage.
- ex_dren  in  1  instruction in EX is a load.
- ex_wsel  in  REGW  destination register of the EX instruction.
- id_rs  in  REGW  rs of the ID instruction.
- id_rt  in  REGW  rt of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- redirect  in  1  taken branch/jump/JR resolved in BR_STAGE.
- wb_halt  in  1  halt instruction in writeback.
- pc_en  out  1  PC update enable.
- latch_en  out  NSTAGES-1  per-latch load enable.
- latch_flush  out  NSTAGES-1  per-latch bubble insert; when set, the same latch_en bit is also 1.
- halted  out  1  core halted.
- stall_cnt  out  CNTW  cycles with pc_en=0, outside HALT.
- flush_cnt  out  CNTW  redirects applied.

Behaviour:
- Reset (nRST=0, asynchronous): state=RUN, rem=0, counters=0. While nRST=0: pc_en=0, latch_en=0, latch_flush=0, halted=0. Reset mid-stall aborts the stall; the core resumes in RUN.
- FSM states: RUN, LDUSE (rem = bubbles left), HALT.
- Outputs are combinational from state and inputs. They are evaluated in the priority order below, first match wins.
- P1, HALT state: pc_en=0, latch_en=0, latch_flush=0, halted=1. HALT is left only by reset.
- P2, dfreeze = (mem_dren|mem_dwen) & !dhit: pc_en=0, latch_en=0, latch_flush=0. State, rem and flush_cnt hold. redirect and wb_halt are ignored; the producing instruction is frozen, so it reasserts them.
- P3, redirect: pc_en=1, latch_en all 1, latch_flush[k]=1 for k<BR_STAGE. Next state RUN, rem=0, flush_cnt+1. ihit is ignored (outstanding fetch is discarded). This aborts any LDUSE in progress.
- P4, load-use: applies in LDUSE, or in RUN when ex_dren & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
  - Outputs: pc_en=0, latch_en[0]=0, latch_flush[1]=1, all other latch_en=1.
  - In RUN: if LOAD_LAT==1 stay RUN, else go LDUSE with rem=LOAD_LAT-1.
  - In LDUSE: rem-1; go to RUN when rem==1.
  - Total bubbles = LOAD_LAT. Frozen (P2) cycles do not count. ihit is irrelevant during P4.
- P5, !ihit: pc_en=0, latch_flush[0]=1, all latch_en=1.
- P6, normal: pc_en=1, all latch_en=1, latch_flush=0.
- Halt: wb_halt=1 in any non-P2 cycle (state RUN or LDUSE) -> HALT next edge. That cycle's outputs follow P3-P6.
- stall_cnt: +1 on each edge where state!=HALT, nRST=1 and pc_en=0. Saturates at all ones.
- flush_cnt: +1 per P3 cycle. Saturates at all ones.

Test Plan:
Defaults NSTAGES=5, BR_STAGE=2, LOAD_LAT=1 unless stated.
1. Async reset: pulse nRST low mid-cycle during LDUSE -> immediately pc_en=0, latch_en=4'b0000, counters=0, halted=0. After release with ihit=1 -> pc_en=1, latch_en=4'b1111.
2. Load-use: ex_dren=1, ex_wsel=8, id_rs=8, ihit=1 -> one cycle pc_en=0, latch_en=4'b1110, latch_flush=4'b0010, then normal. Rerun with LOAD_LAT=3 -> exactly 3 bubble cycles. ex_wsel=0 -> no stall. id_rt=8 with id_uses_rt=0 (id_rs≠8) -> no stall.
3. Data wait: mem_dren=1, dhit=0 for 3 cycles with redirect=1 -> latch_en=4'b0000 and latch_flush=0 for 3 cycles, stall_cnt=3, flush_cnt=0. On dhit=1 -> latch_flush=4'b0011, flush_cnt=1.
4. Redirect during LDUSE (LOAD_LAT=3, second bubble) with ihit=0 -> pc_en=1, latch_flush=4'b0011, state RUN next cycle, no further bubbles.
5. Fetch miss: ihit=0 for 2 cycles, no other hazards -> pc_en=0, latch_en=4'b1111, latch_flush=4'b0001 each cycle; stall_cnt=2.
6. Halt and saturation (CNTW=4): run 20 miss cycles -> stall_cnt=4'hF. Then wb_halt=1 -> halted=1 next cycle, all enables 0, counters frozen, HALT persists until nRST.
